store_narrow_rmw: RTL and testbench

Store-path narrowing unit for the data-memory interface: the write-side counterpart of the load-path sign/zero extension. It takes a 32-bit register value plus byte address and size (SB/SH/SW), selects the low byte or halfword, and places it in the correct lane of a word-only data memory. Sub-word stores use a read-modify-write sequence. It sits between the MEM-stage store control and the synchronous-read data memory.

---
 rtl/store_narrow_rmw.sv | 118 +++++++++++
 tb/tb_store_narrow_rmw.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_rmw.sv
// Store-path narrowing unit: places SB/SH/SW data into a word-only synchronous data memory,
// using read-modify-write for sub-word stores. Optional macro: STORE_MISALIGN_TRAP_EN.
module store_narrow_rmw #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              busy,
    output logic              misalign,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, MRG = 2'd2, WR = 2'd3} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state;
    logic        is_byte_q;
    logic [1:0]  off_q;
    logic [15:0] data_q;
    logic [31:0] merged;
    logic        drop;
    logic [1:0]  req_off;
    logic        unused_addr_bits;

    // Handshake: a request transfers on any rising edge where req_valid && req_ready;
    // req_ready is decoded straight from state, so it is high exactly in IDLE.
    assign req_ready = (state == IDLE);
    assign state_dbg = state;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef STORE_MISALIGN_TRAP_EN
    assign drop = (req_size == SZ_RSVD)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign drop = (req_size == SZ_RSVD);
`endif

    // Halfwords are aligned down to their lane; only bytes keep the full offset.
    assign req_off = (req_size == SZ_BYTE) ? req_addr[1:0] : {req_addr[1], 1'b0};

    always_comb begin
        merged = mem_rd_data;
        if (is_byte_q)
            merged[{off_q, 3'b000} +: 8] = data_q[7:0];
        else
            merged[{off_q[1], 4'b0000} +: 16] = data_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            busy        <= 1'b0;
            misalign    <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            is_byte_q   <= 1'b0;
            off_q       <= 2'b00;
            data_q      <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (drop) begin
                            misalign <= 1'b1;
                        end else begin
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            is_byte_q <= (req_size == SZ_BYTE);
                            off_q     <= req_off;
                            data_q    <= req_data[15:0];
                            busy      <= 1'b1;
                            if (req_size == SZ_WORD) begin
                                mem_wr_data <= req_data;
                                mem_wr_en   <= 1'b1;
                                state       <= WR;
                            end else begin
                                mem_rd_en <= 1'b1;
                                state     <= RD;
                            end
                        end
                    end
                end
                // Memory samples the read strobe this cycle; data shows up in MRG.
                RD: state <= MRG;
                MRG: begin
                    mem_wr_data <= merged;
                    mem_wr_en   <= 1'b1;
                    state       <= WR;
                end
                WR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: directed test-plan steps then random stores checked against
// a word-array reference memory. Honors STORE_MISALIGN_TRAP_EN the same way as the design.
module tb_store_narrow_rmw;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef STORE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_data = '0;
    logic [1:0]        req_size = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_data = '0;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;
    logic              busy;
    logic              misalign;
    logic [1:0]        state_dbg;

    logic [31:0] env_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        fill_en = 1'b0;
    logic        poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    logic [31:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    store_narrow_rmw #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .busy(busy), .misalign(misalign), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #5 Clk = ~Clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fill_fn(input int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Synchronous-read data memory seen by the DUT
    always @(posedge Clk) begin
        if (fill_en)
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= fill_fn(i);
        if (poke_en) env_mem[poke_addr] <= poke_data;
        if (mem_rd_en) mem_rd_data <= env_mem[mem_addr];
        if (mem_wr_en) env_mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int w, input logic [31:0] d);
        @(negedge Clk);
        poke_en = 1'b1; poke_addr = w[ADDR_W-1:0]; poke_data = d;
        @(negedge Clk);
        poke_en = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!req_ready && c < 20) begin
            @(negedge Clk);
            c++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $error("FAIL ready_timeout: observed ready=0 expected ready=1 within 20 cycles");
        end
    endtask

    // Reference: the stored word is the old word with the addressed lane(s) replaced.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [31:0] data, input logic [1:0] size);
        int sh;
        logic [31:0] m;
        if (size == 2'b10) return data;
        if (size == 2'b00) begin
            sh = 8 * int'(addr[1:0]);
            m  = 32'hFF << sh;
            return (old & ~m) | ((data & 32'hFF) << sh);
        end
        sh = addr[1] ? 16 : 0;
        m  = 32'hFFFF << sh;
        return (old & ~m) | ((data & 32'hFFFF) << sh);
    endfunction

    // kind: 0 rejected, 1 word, 2 sub-word
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        int kind, w, rdy_at;
        bit mis;
        logic [31:0] neww, got;
        mis = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        if (size == 2'b11 || (TRAP && mis)) kind = 0;
        else if (size == 2'b10) kind = 1;
        else kind = 2;
        w = int'(addr[ADDR_W+1:2]);
        neww = ref_merge(ref_mem[w], addr, data, size);
        rdy_at = (kind == 0) ? 1 : (kind == 1) ? 2 : 4;
        wait_ready();
        req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
        @(posedge Clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
        if (kind != 0) exp_q.push_back(neww);
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clk);
            check($sformatf("rd_en c%0d sz%0d", c, size), 32'(mem_rd_en), 32'(kind == 2 && c == 1));
            check($sformatf("wr_en c%0d sz%0d", c, size), 32'(mem_wr_en),
                  32'((kind == 1 && c == 1) || (kind == 2 && c == 3)));
            check($sformatf("misalign c%0d", c), 32'(misalign), 32'(kind == 0 && c == 1));
            check($sformatf("ready c%0d", c), 32'(req_ready), 32'(c >= rdy_at));
            check($sformatf("busy c%0d", c), 32'(busy), 32'(c < rdy_at));
            if ((kind == 2 && c <= 3) || (kind == 1 && c == 1))
                check($sformatf("mem_addr c%0d", c), 32'(mem_addr), 32'(w));
            if (mem_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_write: observed 0x%08h expected none", mem_wr_data);
                end else begin
                    got = exp_q.pop_front();
                    check("wr_data", mem_wr_data, got);
                end
            end
        end
        if (kind != 0) ref_mem[w] = neww;
        check($sformatf("mem_word[%0d]", w), env_mem[w], ref_mem[w]);
    endtask

    initial begin
        int first;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_fn(i);

        // Reset and memory fill
        fill_en = 1'b1;
        @(negedge Clk);
        fill_en = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", mem_wr_data, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);

        // Directed steps from the test plan
        do_store(32'h10, 32'hDEADBEEF, 2'b10);
        check("sw_word4", env_mem[4], 32'hDEADBEEF);
        poke(4, 32'h11223344);
        do_store(32'h13, 32'h123456AB, 2'b00);
        check("sb_word4", env_mem[4], 32'hAB223344);
        poke(8, 32'h0);
        do_store(32'h22, 32'hFFFFCAFE, 2'b01);
        check("sh_word8", env_mem[8], 32'hCAFE0000);
        poke(8, 32'h0);
        do_store(32'h23, 32'hFFFFCAFE, 2'b01);
        check("sh_mis_word8", env_mem[8], TRAP ? 32'h0 : 32'hCAFE0000);
        do_store(32'h40, 32'h0BADF00D, 2'b11);
        do_store(32'h46, 32'h13572468, 2'b10);

        // Reset during a byte store discards the pending write
        wait_ready();
        req_valid = 1'b1; req_addr = 32'h31; req_data = 32'h77; req_size = 2'b00;
        @(posedge Clk);
        #1 req_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wr_data", mem_wr_data, 32'd0);
        Reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            check($sformatf("post_rst_wr_en c%0d", c), 32'(mem_wr_en), 32'd0);
        end
        check("mid_rst_word12", env_mem[12], ref_mem[12]);

        // Back-to-back with req_valid held high
        wait_ready();
        req_valid = 1'b1; req_addr = 32'h0; req_data = 32'h55; req_size = 2'b00;
        @(posedge Clk);
        #1 req_addr = 32'h1; req_data = 32'h66;
        first = 0;
        for (int c = 1; c <= 8 && first == 0; c++) begin
            @(negedge Clk);
            if (req_ready) first = c;
        end
        check("b2b_spacing", 32'(first), 32'd4);
        @(posedge Clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge Clk);
        ref_mem[0] = ref_merge(ref_merge(ref_mem[0], 32'h0, 32'h55, 2'b00), 32'h1, 32'h66, 2'b00);
        check("b2b_low_half", 32'(env_mem[0][15:0]), 32'h6655);
        check("b2b_word0", env_mem[0], ref_mem[0]);

        // Random stores against the reference memory
        for (int i = 0; i < 60; i++)
            do_store($urandom_range(0, 255) | ($urandom & 32'hFFFF_F000), $urandom, 2'($urandom_range(0, 3)));

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
